// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier control unit:
// state encoding, default operand width, Booth decision codes and the
// per-state strobe decode used to build the registered outputs.
package booth_pkg;

  localparam int N_DEFAULT = 4;

  // Booth decision codes on {q0, qm1}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SUB   = 3'd4,
    ST_SHIFT = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic carga_m;
    logic carga_q;
    logic clear_a;
    logic carga_a;
    logic resta;
    logic desplaza_a;
    logic desplaza_q;
    logic fin;
    logic busy;
  } strobes_t;

  // Moore output decode: strobes that belong to a given state.
  // Unknown encodings decode to all-zero so nothing fires while recovering.
  function automatic strobes_t decode_strobes(input state_t s);
    strobes_t st;
    st = '0;
    case (s)
      ST_LOAD: begin
        st.carga_m = 1'b1;
        st.carga_q = 1'b1;
        st.clear_a = 1'b1;
        st.busy    = 1'b1;
      end
      ST_TEST: begin
        st.busy = 1'b1;
      end
      ST_ADD: begin
        st.carga_a = 1'b1;
        st.resta   = 1'b0;
        st.busy    = 1'b1;
      end
      ST_SUB: begin
        st.carga_a = 1'b1;
        st.resta   = 1'b1;
        st.busy    = 1'b1;
      end
      ST_SHIFT: begin
        st.desplaza_a = 1'b1;
        st.desplaza_q = 1'b1;
        st.busy       = 1'b1;
      end
      ST_DONE: begin
        st.fin = 1'b1;
      end
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/booth_cnt.sv
// Loadable down counter tracking the remaining Booth iterations.
// Loads N, decrements on request, never wraps below zero.
module booth_cnt #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  // Iteration count: load wins over decrement; saturates at zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CNT_W'(N);
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == CNT_W'(1));

endmodule

// File: rtl/booth_ctrl.sv
// Moore control unit for a radix-2 Booth multiplier datapath (A, M, Q, q(-1)).
// Strobes are registered: each edge stores the decode of the state being
// entered, so the outputs always correspond to the registered state.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  output logic CargaM,
  output logic CargaQ,
  output logic ClearA,
  output logic CargaA,
  output logic Resta,
  output logic DesplazaA,
  output logic DesplazaQ,
  output logic Fin,
  output logic busy
);

  localparam int CNT_W = $clog2(N + 1);

  state_t           state_reg;
  state_t           state_next;
  strobes_t         strobes_reg;
  logic [CNT_W-1:0] count;
  logic             last;
  logic             cnt_load;
  logic             cnt_dec;

  // Counter is loaded in LOAD and stepped once per SHIFT only
  assign cnt_load = (state_reg == ST_LOAD);
  assign cnt_dec  = (state_reg == ST_SHIFT) && (count != '0);

  booth_cnt #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .count (count),
    .last  (last)
  );

  // Next-state choice; q0/qm1 only steer the TEST branch
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE:  state_next = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_next = ST_TEST;
      ST_TEST: begin
        case ({q0, qm1})
          BOOTH_SUB: state_next = ST_SUB;
          BOOTH_ADD: state_next = ST_ADD;
          default:   state_next = ST_SHIFT;
        endcase
      end
      ST_ADD:   state_next = ST_SHIFT;
      ST_SUB:   state_next = ST_SHIFT;
      ST_SHIFT: state_next = last ? ST_DONE : ST_TEST;
      ST_DONE:  state_next = start ? ST_DONE : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register with strobes registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      strobes_reg <= '0;
    end else begin
      state_reg   <= state_next;
      strobes_reg <= decode_strobes(state_next);
    end
  end

  assign CargaM    = strobes_reg.carga_m;
  assign CargaQ    = strobes_reg.carga_q;
  assign ClearA    = strobes_reg.clear_a;
  assign CargaA    = strobes_reg.carga_a;
  assign Resta     = strobes_reg.resta;
  assign DesplazaA = strobes_reg.desplaza_a;
  assign DesplazaQ = strobes_reg.desplaza_q;
  assign Fin       = strobes_reg.fin;
  assign busy      = strobes_reg.busy;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: models the A/M/Q datapath around the controller,
// queues expected results from an independent Booth recoding model when an
// operation is launched, and compares when Fin appears.
module tb_booth_ctrl;

  localparam int N = 4;

  typedef struct {
    logic [7:0] prod;
    int         lat;
    int         nops;
    logic [7:0] seq;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic q0, qm1;
  logic CargaM, CargaQ, ClearA, CargaA, Resta, DesplazaA, DesplazaQ, Fin, busy;

  // datapath model
  logic [3:0] a_reg = '0, q_reg = '0, m_reg = '0;
  logic       qm1_reg = 1'b0;
  logic [3:0] q_in = '0, m_in = '0;

  // strobe monitor
  int         carga_a_cnt = 0, shift_cnt = 0, load_cnt = 0, viol_cnt = 0;
  logic [7:0] resta_log = '0;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  assign q0  = q_reg[0];
  assign qm1 = qm1_reg;

  booth_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q0        (q0),
    .qm1       (qm1),
    .CargaM    (CargaM),
    .CargaQ    (CargaQ),
    .ClearA    (ClearA),
    .CargaA    (CargaA),
    .Resta     (Resta),
    .DesplazaA (DesplazaA),
    .DesplazaQ (DesplazaQ),
    .Fin       (Fin),
    .busy      (busy)
  );

  // datapath registers react to the strobes present during the cycle
  always @(posedge clk) begin
    if (CargaM) m_reg <= m_in;
    if (CargaQ) begin
      q_reg   <= q_in;
      qm1_reg <= 1'b0;
    end
    if (ClearA) a_reg <= '0;
    if (CargaA) a_reg <= Resta ? (a_reg - m_reg) : (a_reg + m_reg);
    if (DesplazaA) a_reg <= {a_reg[3], a_reg[3:1]};
    if (DesplazaQ) begin
      q_reg   <= {a_reg[0], q_reg[3:1]};
      qm1_reg <= q_reg[0];
    end
  end

  // strobe statistics and exclusivity watch
  always @(posedge clk) begin
    if (CargaA) begin
      carga_a_cnt <= carga_a_cnt + 1;
      resta_log   <= {resta_log[6:0], Resta};
    end
    if (DesplazaA) shift_cnt <= shift_cnt + 1;
    if (CargaM) load_cnt <= load_cnt + 1;
    if ((CargaA | CargaM | CargaQ | ClearA) & (DesplazaA | DesplazaQ)) viol_cnt <= viol_cnt + 1;
    if (DesplazaA != DesplazaQ) viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] all_outs();
    return {CargaM, CargaQ, ClearA, CargaA, Resta, DesplazaA, DesplazaQ, Fin, busy};
  endfunction

  task automatic run_op(input logic [3:0] qv, input logic [3:0] mv, input bit hold, input bit glitch);
    exp_t e;
    int   edges, p, ca0, sh0, ld0, vi0;
    bit   fin_seen;
    logic prev;
    logic [7:0] mask;
    // reference: Booth recoding of the multiplier, q(-1)=0 initially
    e.nops = 0;
    e.seq  = '0;
    prev   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (qv[i] && !prev) begin
        e.nops++;
        e.seq = {e.seq[6:0], 1'b1};
      end else if (!qv[i] && prev) begin
        e.nops++;
        e.seq = {e.seq[6:0], 1'b0};
      end
      prev = qv[i];
    end
    e.lat  = 2 * N + 2 + e.nops;
    p      = int'($signed(qv)) * int'($signed(mv));
    e.prod = p[7:0];
    sb_q.push_back(e);

    q_in = qv;
    m_in = mv;
    ca0 = carga_a_cnt;
    sh0 = shift_cnt;
    ld0 = load_cnt;
    vi0 = viol_cnt;
    @(negedge clk);
    start = 1'b1;
    edges = 0;
    fin_seen = 1'b0;
    while (!fin_seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) check("load_strobes", 32'(CargaM & CargaQ & ClearA & busy), 32'd1);
      if (Fin) fin_seen = 1'b1;
      else if (glitch) start = (edges >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    check("fin_seen", 32'(fin_seen), 32'd1);
    e = sb_q.pop_front();
    if (fin_seen) begin
      check("latency", 32'(edges), 32'(e.lat));
      check("product", 32'({a_reg, q_reg}), 32'(e.prod));
      check("addsub_cnt", 32'(carga_a_cnt - ca0), 32'(e.nops));
      check("shift_cnt", 32'(shift_cnt - sh0), 32'(N));
      check("exclusive", 32'(viol_cnt - vi0), 32'd0);
      check("busy_done", 32'(busy), 32'd0);
      if (e.nops > 0) begin
        mask = 8'((1 << e.nops) - 1);
        check("resta_seq", 32'(resta_log & mask), 32'(e.seq & mask));
      end
    end
    $display("op Q=%b M=%b lat=%0d AQ=%h expected lat=%0d AQ=%h", qv, mv, edges, {a_reg, q_reg}, e.lat, e.prod);
    if (hold) begin
      ld0 = load_cnt;
      repeat (3) begin
        @(posedge clk);
        #1;
        check("fin_hold", 32'(Fin), 32'd1);
      end
      check("no_reload", 32'(load_cnt - ld0), 32'd0);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check("fin_drop", 32'(Fin), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int  n;
    bit  hit;
    // reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(all_outs()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_outs", 32'(all_outs()), 32'd0);

    run_op(4'b0000, 4'b0011, 1'b0, 1'b0);  // shift only, 0
    run_op(4'b0101, 4'b0011, 1'b0, 1'b0);  // SUB ADD SUB ADD, 15
    run_op(4'b1111, 4'b0011, 1'b0, 1'b0);  // one SUB, -3
    run_op(4'b0110, 4'b0101, 1'b1, 1'b0);  // hold start through DONE
    run_op(4'b0101, 4'b0011, 1'b0, 1'b0);  // restart after drop
    run_op(4'b0101, 4'b0011, 1'b0, 1'b1);  // start toggled while busy
    run_op(4'b1000, 4'b0111, 1'b0, 1'b0);  // most negative multiplier

    // reset in the SUB of iteration 2 (Q=0110: shift-only, then SUB)
    q_in = 4'b0110;
    m_in = 4'b0011;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (CargaA && Resta) hit = 1'b1;
    end
    check("sub_reached", 32'(hit), 32'd1);
    check("sub_edge", 32'(n), 32'd5);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midop_reset", 32'(all_outs()), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 32'(all_outs()), 32'd0);
    $display("reset applied mid-operation after %0d edges", n);
    run_op(4'b0101, 4'b0011, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
